// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external memory bus arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state encoding (3 bits), a15 byte-select constants, timer width.
package mem_bus_pkg;

    localparam int TIMER_W = 3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP_HI  = 3'd1;
    localparam logic [2:0] ST_STROBE_HI = 3'd2;
    localparam logic [2:0] ST_HOLD_HI   = 3'd3;
    localparam logic [2:0] ST_SETUP_LO  = 3'd4;
    localparam logic [2:0] ST_STROBE_LO = 3'd5;
    localparam logic [2:0] ST_HOLD_LO   = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SETUP_HI  = ST_SETUP_HI,
        STROBE_HI = ST_STROBE_HI,
        HOLD_HI   = ST_HOLD_HI,
        SETUP_LO  = ST_SETUP_LO,
        STROBE_LO = ST_STROBE_LO,
        HOLD_LO   = ST_HOLD_LO,
        DONE      = ST_DONE
    } state_t;

    // a15 value per byte phase: the HI phase moves word[8:15] (the LSB byte).
    localparam logic BYTE_HI = 1'b1;
    localparam logic BYTE_LO = 1'b0;

endpackage

// File: rtl/mem_cycle_timer.sv
// Loadable down-counter that times the SETUP and STROBE phases of a byte cycle.
// Latency: load takes effect on the next edge; expired is combinational from the count.
// Backpressure: none; counting stops at zero and never wraps.
// Ports: clk, reset (async high), load/load_val (reload), dec (count down), expired (count==0).
module mem_cycle_timer
    import mem_bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit memory bus between CPU (r0) and DMA (r1) 16-bit word requests.
// Latency: req sampled in IDLE -> ack after 1 + 2*(SETUP_CYC + STROBE_CYC + 1) cycles.
// Backpressure: requesters hold req until ack; optional ready (MEM_ARB_READY_EN) stretches strobes.
// Ports: req/wr/addr/wdata per requester in, ack per requester out, rdata out;
//        memen/we/dbin/a15/addr_bus out and data_bus inout towards the memory.
// Optional: define MEM_ARB_READY_EN to add the ready input.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,   // 1..7
    parameter int STROBE_CYC = 2    // 1..7
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_ARB_READY_EN
    input  logic        ready,
`endif
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [0:14] addr0,
    input  logic [0:14] addr1,
    input  logic [0:15] wdata0,
    input  logic [0:15] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [0:15] rdata,
    output logic        memen,
    output logic        we,
    output logic        dbin,
    output logic        a15,
    output logic [0:14] addr_bus,
    inout  wire  [0:7]  data_bus
);

    localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] STROBE_LD = TIMER_W'(STROBE_CYC - 1);

    state_t              state, state_nxt;
    logic                tmr_load, tmr_dec, tmr_expired;
    logic [TIMER_W-1:0]  tmr_val;
    logic                take, cap_hi, cap_lo, strobe_go;
    logic                pick1, last_gnt, gnt_q, wr_q;
    logic [0:14]         addr_q;
    logic [0:15]         wdata_q;
    logic                active, is_hi, strobe;

`ifdef MEM_ARB_READY_EN
    assign strobe_go = tmr_expired && ready;
`else
    assign strobe_go = tmr_expired;
`endif

    // r1 wins when it is alone, or when both request and r0 was served last.
    assign pick1 = req1 && (!req0 || !last_gnt);

    mem_cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Every transition reloads the timer with the dwell of the state being entered.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = '0;
        take      = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        case (state)
            IDLE: if (req0 || req1) begin
                state_nxt = SETUP_HI; tmr_load = 1'b1; tmr_val = SETUP_LD; take = 1'b1;
            end
            SETUP_HI: if (tmr_expired) begin
                state_nxt = STROBE_HI; tmr_load = 1'b1; tmr_val = STROBE_LD;
            end else tmr_dec = 1'b1;
            STROBE_HI: if (strobe_go) begin
                state_nxt = HOLD_HI; tmr_load = 1'b1; cap_hi = !wr_q;
            end else tmr_dec = 1'b1;
            HOLD_HI: begin
                state_nxt = SETUP_LO; tmr_load = 1'b1; tmr_val = SETUP_LD;
            end
            SETUP_LO: if (tmr_expired) begin
                state_nxt = STROBE_LO; tmr_load = 1'b1; tmr_val = STROBE_LD;
            end else tmr_dec = 1'b1;
            STROBE_LO: if (strobe_go) begin
                state_nxt = HOLD_LO; tmr_load = 1'b1; cap_lo = !wr_q;
            end else tmr_dec = 1'b1;
            HOLD_LO: begin
                state_nxt = DONE; tmr_load = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE; tmr_load = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are latched at grant so requester changes mid-cycle are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;   // "r1 served last" so r0 wins the first tie
            gnt_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (take) begin
            last_gnt <= pick1;
            gnt_q    <= pick1;
            wr_q     <= pick1 ? wr1    : wr0;
            addr_q   <= pick1 ? addr1  : addr0;
            wdata_q  <= pick1 ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            if (cap_hi) rdata[8:15] <= data_bus;
            if (cap_lo) rdata[0:7]  <= data_bus;
        end
    end

    assign active = (state != IDLE) && (state != DONE);
    assign is_hi  = (state == SETUP_HI) || (state == STROBE_HI) || (state == HOLD_HI);
    assign strobe = (state == STROBE_HI) || (state == STROBE_LO);

    assign memen = !active;
    assign we    = !(strobe && wr_q);
    assign dbin  = strobe && !wr_q;
    assign ack0  = (state == DONE) && !gnt_q;
    assign ack1  = (state == DONE) && gnt_q;

    assign a15      = active ? (is_hi ? BYTE_HI : BYTE_LO) : 1'bz;
    assign addr_bus = active ? addr_q : 15'bz;
    assign data_bus = (active && wr_q) ? (is_hi ? wdata_q[8:15] : wdata_q[0:7]) : 8'bz;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: write, read, round-robin, reset abort, dropped request,
// and (with MEM_ARB_READY_EN) ready-stretched strobe.
// Ports of the DUT are all connected; memory side is modelled by a tri-state driver.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [0:14] addr0, addr1;
    logic [0:15] wdata0, wdata1;
    logic        ack0, ack1;
    logic [0:15] rdata;
    logic        memen, we, dbin;
    wire         a15;
    wire  [0:14] addr_bus;
    wire  [0:7]  data_bus;
    logic        mem_oe;
    logic [0:7]  mem_drv;
`ifdef MEM_ARB_READY_EN
    logic        ready;
`endif

    int checks   = 0;
    int failures = 0;

    assign data_bus = mem_oe ? mem_drv : 8'bz;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MEM_ARB_READY_EN
        .ready    (ready),
`endif
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .memen    (memen),
        .we       (we),
        .dbin     (dbin),
        .a15      (a15),
        .addr_bus (addr_bus),
        .data_bus (data_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_memen"}, 32'(memen), 32'd1);
        chk({tag, "_idle_we"},    32'(we),    32'd1);
        chk({tag, "_idle_ack0"},  32'(ack0),  32'd0);
        chk({tag, "_idle_ack1"},  32'(ack1),  32'd0);
    endtask

    // Steps through one word transfer starting from IDLE with the request already driven.
    // Cycle c=1 is SETUP_HI; the HI half spans 4+stall cycles, LO half 4, DONE is last.
    // word is the write data or, for reads, the word the memory returns (= expected rdata).
    // drop_cyc: at that cycle r0's request is dropped and its operands scrambled.
    // rel: at DONE, release the granted requester's req.
    task automatic run_word(input string tag, input logic is_wr, input logic gnt1,
                            input logic [0:14] addr, input logic [0:15] word,
                            input int stall, input int drop_cyc, input logic rel);
        int         n;
        logic       act, hi, stb, done;
        logic [0:7] byte_v;
        n = 9 + stall;
        for (int c = 1; c <= n; c++) begin
            tick();
            act    = (c <= 8 + stall);
            hi     = (c <= 4 + stall);
            stb    = (c >= 2 && c <= 3 + stall) || (c == 6 + stall) || (c == 7 + stall);
            done   = (c == n);
            byte_v = hi ? word[8:15] : word[0:7];
            mem_oe  = act && !is_wr;
            mem_drv = (c == 3 + stall || c == 7 + stall) ? byte_v : 8'hEE;
`ifdef MEM_ARB_READY_EN
            ready = !(c >= 3 && c <= 2 + stall);
`endif
            if (c == drop_cyc) begin
                req0   = 1'b0;
                wdata0 = 16'hDEAD;
                addr0  = 15'h0F0F;
                wr0    = ~wr0;
            end
            #1;
            chk($sformatf("%s_c%0d_memen", tag, c), 32'(memen), 32'(!act));
            chk($sformatf("%s_c%0d_we", tag, c),    32'(we),    32'(!(stb && is_wr)));
            chk($sformatf("%s_c%0d_dbin", tag, c),  32'(dbin),  32'(stb && !is_wr));
            chk($sformatf("%s_c%0d_ack0", tag, c),  32'(ack0),  32'(done && !gnt1));
            chk($sformatf("%s_c%0d_ack1", tag, c),  32'(ack1),  32'(done && gnt1));
            if (act) begin
                chk($sformatf("%s_c%0d_a15", tag, c),  32'(a15),      32'(hi));
                chk($sformatf("%s_c%0d_addr", tag, c), 32'(addr_bus), 32'(addr));
                if (is_wr) chk($sformatf("%s_c%0d_data", tag, c), 32'(data_bus), 32'(byte_v));
            end
            if (done) begin
                if (!is_wr) chk({tag, "_rdata"}, 32'(rdata), 32'(word));
                if (rel) begin
                    if (gnt1) req1 = 1'b0;
                    else      req0 = 1'b0;
                end
            end
        end
        mem_oe = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_oe = 1'b0; mem_drv = '0;
`ifdef MEM_ARB_READY_EN
        ready = 1'b1;
`endif
        repeat (2) tick();
        chk_idle("rst");
        chk("rst_dbin",  32'(dbin),  32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("post_rst");

        // 1: r0 write; 0x5A with a15=1 then 0xA5 with a15=0, ack0 at cycle 9.
        wr0 = 1'b1; addr0 = 15'h1234; wdata0 = 16'hA55A; req0 = 1'b1;
        run_word("t1", 1'b1, 1'b0, 15'h1234, 16'hA55A, 0, 0, 1'b1);
        tick();
        chk_idle("t1");

        // 2: r1 read; memory returns 0x3C (HI) then 0xC3 (LO) -> rdata 0xC33C.
        wr1 = 1'b0; addr1 = 15'h2A5C; req1 = 1'b1;
        run_word("t2", 1'b0, 1'b1, 15'h2A5C, 16'hC33C, 0, 0, 1'b1);
        tick();
        chk_idle("t2");
        chk("t2_rdata_hold", 32'(rdata), 32'h0000C33C);

        // 3: both held -> r0, r1, r0, r1 with a single IDLE cycle between words.
        wr0 = 1'b1; addr0 = 15'h0111; wdata0 = 16'h1122;
        wr1 = 1'b1; addr1 = 15'h7ABC; wdata1 = 16'h3344;
        req0 = 1'b1; req1 = 1'b1;
        run_word("t3a", 1'b1, 1'b0, 15'h0111, 16'h1122, 0, 0, 1'b0);
        tick(); chk_idle("t3a");
        run_word("t3b", 1'b1, 1'b1, 15'h7ABC, 16'h3344, 0, 0, 1'b0);
        tick(); chk_idle("t3b");
        run_word("t3c", 1'b1, 1'b0, 15'h0111, 16'h1122, 0, 0, 1'b0);
        tick(); chk_idle("t3c");
        run_word("t3d", 1'b1, 1'b1, 15'h7ABC, 16'h3344, 0, 2, 1'b1);
        tick(); chk_idle("t3_end1");
        tick(); chk_idle("t3_end2");
        chk("t3_rdata_kept", 32'(rdata), 32'h0000C33C);

        // 4: reset in STROBE_LO of a write aborts at once with no ack; retry restarts at SETUP_HI.
        wr0 = 1'b1; addr0 = 15'h0055; wdata0 = 16'hBEEF; req0 = 1'b1;
        repeat (6) tick();
        chk("t4_in_strobe_we", 32'(we),  32'd0);
        chk("t4_in_strobe_a15", 32'(a15), 32'd0);
        reset = 1'b1;
        #1;
        chk_idle("t4_rst_now");
        repeat (2) begin
            tick();
            chk_idle("t4_rst_hold");
        end
        chk("t4_rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        run_word("t4r", 1'b1, 1'b0, 15'h0055, 16'hBEEF, 0, 0, 1'b1);
        tick(); chk_idle("t4r");

        // 5: r0 drops req in SETUP_LO and changes wdata; latched word completes, ack0 pulses.
        wr0 = 1'b1; addr0 = 15'h3210; wdata0 = 16'h5AA5; req0 = 1'b1;
        run_word("t5", 1'b1, 1'b0, 15'h3210, 16'h5AA5, 0, 5, 1'b1);
        tick(); chk_idle("t5_a");
        tick(); chk_idle("t5_b");

`ifdef MEM_ARB_READY_EN
        // 6: ready low for 3 expired strobe cycles in STROBE_HI -> we low 5 cycles, ack at cycle 12.
        wr0 = 1'b1; addr0 = 15'h0F00; wdata0 = 16'h1357; req0 = 1'b1;
        run_word("t6", 1'b1, 1'b0, 15'h0F00, 16'h1357, 3, 0, 1'b1);
        tick(); chk_idle("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
